controle_varredura_matriz: RTL and testbench

//  Scan controller for the 5x7 LED matrix driven by the game-select patterns (coluna1..coluna5).

---
 rtl/controle_varredura_matriz_pkg.sv | 12 +
 rtl/contador_tempo.sv | 32 +++
 rtl/controle_varredura_matriz.sv | 135 +++++++++++++
 tb/tb_controle_varredura_matriz.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/controle_varredura_matriz_pkg.sv
// Shared constants and FSM encoding for the 5x7 LED matrix scan controller.
package controle_varredura_matriz_pkg;
  localparam int NUM_COLUNAS = 5;
  localparam int LARGURA_LINHA = 7;
  localparam logic [LARGURA_LINHA-1:0] APAGADO = 7'h7F;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    EXIBE  = 2'd1,
    APAGA  = 2'd2
  } estado_t;
endpackage

// File: rtl/contador_tempo.sv
// Loadable down-counter; terminal is high while the count sits at zero.
// A load takes priority over counting; the count holds at zero until reloaded.
module contador_tempo #(
  parameter int LARGURA = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               carregar,
  input  logic [LARGURA-1:0] valor,
  output logic               terminal
);
  logic [LARGURA-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (carregar) begin
      cnt_d = valor;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign terminal = (cnt_q == '0);
endmodule

// File: rtl/controle_varredura_matriz.sv
// Column-scan controller for a 5x7 LED matrix with a frame-synchronous double buffer.
// Pins are registered one cycle behind the FSM; loads are deferred to the frame boundary.
module controle_varredura_matriz
  import controle_varredura_matriz_pkg::*;
#(
  parameter int DIV_COLUNA   = 50000,
  parameter int BLANK_CICLOS = 500
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LARGURA_LINHA-1:0] coluna1,
  input  logic [LARGURA_LINHA-1:0] coluna2,
  input  logic [LARGURA_LINHA-1:0] coluna3,
  input  logic [LARGURA_LINHA-1:0] coluna4,
  input  logic [LARGURA_LINHA-1:0] coluna5,
  input  logic                     carregar,
  input  logic                     habilita,
  output logic [LARGURA_LINHA-1:0] linhas,
  output logic [NUM_COLUNAS-1:0]   colunas,
  output logic                     carregado,
  output logic                     fim_quadro
);
  localparam int MAX_CICLOS  = (DIV_COLUNA > BLANK_CICLOS) ? DIV_COLUNA : BLANK_CICLOS;
  localparam int LARGURA_CNT = $clog2(MAX_CICLOS + 1);
  localparam logic [LARGURA_CNT-1:0] CARGA_EXIBE = LARGURA_CNT'(DIV_COLUNA - 1);
  localparam logic [LARGURA_CNT-1:0] CARGA_APAGA =
    LARGURA_CNT'((BLANK_CICLOS > 0) ? BLANK_CICLOS - 1 : 0);
  localparam logic [2:0] ULTIMA = 3'(NUM_COLUNAS - 1);

  estado_t estado_q, estado_d;
  logic [2:0] idx_q, idx_d;
  logic [NUM_COLUNAS-1:0][LARGURA_LINHA-1:0] buffer_q, buffer_d;
  logic pendente_q, pendente_d;
  logic [LARGURA_LINHA-1:0] linhas_q, linhas_d;
  logic [NUM_COLUNAS-1:0] colunas_q, colunas_d;
  logic carregado_q, carregado_d;
  logic fim_quadro_q, fim_quadro_d;

  logic cnt_carga, cnt_fim, virada, trava;
  logic [LARGURA_CNT-1:0] cnt_valor;

  contador_tempo #(.LARGURA(LARGURA_CNT)) u_contador (
    .clk      (clk),
    .reset    (reset),
    .carregar (cnt_carga),
    .valor    (cnt_valor),
    .terminal (cnt_fim)
  );

  always_comb begin
    estado_d  = estado_q;
    idx_d     = idx_q;
    cnt_carga = 1'b0;
    cnt_valor = '0;
    virada    = 1'b0;
    case (estado_q)
      OCIOSO: begin
        cnt_carga = 1'b1;
        if (habilita) begin
          estado_d  = EXIBE;
          idx_d     = '0;
          cnt_valor = CARGA_EXIBE;
        end
      end
      EXIBE, APAGA: begin
        if (!habilita) begin
          estado_d  = OCIOSO;
          idx_d     = '0;
          cnt_carga = 1'b1;
        end else if (cnt_fim) begin
          cnt_carga = 1'b1;
          if (estado_q == EXIBE && BLANK_CICLOS > 0) begin
            estado_d  = APAGA;
            cnt_valor = CARGA_APAGA;
          end else begin
            estado_d  = EXIBE;
            cnt_valor = CARGA_EXIBE;
            if (idx_q == ULTIMA) begin
              idx_d  = '0;
              virada = 1'b1;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
      end
      default: begin
        estado_d  = OCIOSO;
        idx_d     = '0;
        cnt_carga = 1'b1;
      end
    endcase

    // A request arriving on the boundary edge itself is merged into that same latch.
    trava        = (virada || estado_q == OCIOSO) && (pendente_q || carregar);
    pendente_d   = !trava && (pendente_q || carregar);
    buffer_d     = trava ? {coluna5, coluna4, coluna3, coluna2, coluna1} : buffer_q;
    carregado_d  = trava;
    fim_quadro_d = virada;

    linhas_d  = APAGADO;
    colunas_d = '0;
    if (estado_q == EXIBE) begin
      linhas_d  = buffer_q[idx_q];
      colunas_d = NUM_COLUNAS'(1) << idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q     <= OCIOSO;
      idx_q        <= '0;
      buffer_q     <= {NUM_COLUNAS{APAGADO}};
      pendente_q   <= 1'b0;
      linhas_q     <= APAGADO;
      colunas_q    <= '0;
      carregado_q  <= 1'b0;
      fim_quadro_q <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      idx_q        <= idx_d;
      buffer_q     <= buffer_d;
      pendente_q   <= pendente_d;
      linhas_q     <= linhas_d;
      colunas_q    <= colunas_d;
      carregado_q  <= carregado_d;
      fim_quadro_q <= fim_quadro_d;
    end
  end

  assign linhas     = linhas_q;
  assign colunas    = colunas_q;
  assign carregado  = carregado_q;
  assign fim_quadro = fim_quadro_q;
endmodule

// File: tb/tb_controle_varredura_matriz.sv
// Bench for controle_varredura_matriz: one instance with a blanking gap, one without,
// both checked every cycle against a frame-position reference model.
module tb_controle_varredura_matriz;
  localparam int D  = 4;
  localparam int B0 = 2;
  localparam int P0 = D + B0;
  localparam int F0 = 5 * P0;

  logic clk = 1'b0;
  logic reset, carregar, habilita;
  logic [6:0] coluna1, coluna2, coluna3, coluna4, coluna5;

  logic [6:0] linhas_a, linhas_b;
  logic [4:0] colunas_a, colunas_b;
  logic carregado_a, carregado_b, fim_quadro_a, fim_quadro_b;

  int checks = 0;
  int errors = 0;

  // Reference model: running flag, position in frame, display buffer, pending load.
  bit         m_run  [2];
  int         m_t    [2];
  bit         m_pend [2];
  logic [6:0] m_buf  [2][5];
  logic [6:0] e_lin  [2];
  logic [4:0] e_col  [2];
  logic       e_fim  [2];
  logic       e_car  [2];

  controle_varredura_matriz #(.DIV_COLUNA(D), .BLANK_CICLOS(B0)) dut_a (
    .clk(clk), .reset(reset),
    .coluna1(coluna1), .coluna2(coluna2), .coluna3(coluna3), .coluna4(coluna4), .coluna5(coluna5),
    .carregar(carregar), .habilita(habilita),
    .linhas(linhas_a), .colunas(colunas_a), .carregado(carregado_a), .fim_quadro(fim_quadro_a)
  );

  controle_varredura_matriz #(.DIV_COLUNA(D), .BLANK_CICLOS(0)) dut_b (
    .clk(clk), .reset(reset),
    .coluna1(coluna1), .coluna2(coluna2), .coluna3(coluna3), .coluna4(coluna4), .coluna5(coluna5),
    .carregar(carregar), .habilita(habilita),
    .linhas(linhas_b), .colunas(colunas_b), .carregado(carregado_b), .fim_quadro(fim_quadro_b)
  );

  always #5 clk = ~clk;

  task automatic modelo(input int i);
    int p;
    int f;
    int c;
    p = D + ((i == 0) ? B0 : 0);
    f = 5 * p;
    if (reset) begin
      m_run[i] = 1'b0;
      m_t[i] = 0;
      m_pend[i] = 1'b0;
      for (int k = 0; k < 5; k++) m_buf[i][k] = 7'h7F;
      e_lin[i] = 7'h7F;
      e_col[i] = 5'b0;
      e_fim[i] = 1'b0;
      e_car[i] = 1'b0;
    end else begin
      c = m_t[i] / p;
      if (m_run[i] && (m_t[i] % p) < D) begin
        e_col[i] = 5'(1 << c);
        e_lin[i] = m_buf[i][c];
      end else begin
        e_col[i] = 5'b0;
        e_lin[i] = 7'h7F;
      end
      e_fim[i] = m_run[i] && habilita && (m_t[i] == f - 1);
      e_car[i] = (e_fim[i] || !m_run[i]) && (m_pend[i] || carregar);
      if (e_car[i]) begin
        m_buf[i][0] = coluna1;
        m_buf[i][1] = coluna2;
        m_buf[i][2] = coluna3;
        m_buf[i][3] = coluna4;
        m_buf[i][4] = coluna5;
        m_pend[i] = 1'b0;
      end else if (carregar) begin
        m_pend[i] = 1'b1;
      end
      if (m_run[i]) begin
        if (!habilita) begin
          m_run[i] = 1'b0;
          m_t[i] = 0;
        end else begin
          m_t[i] = (m_t[i] + 1) % f;
        end
      end else if (habilita) begin
        m_run[i] = 1'b1;
        m_t[i] = 0;
      end
    end
  endtask

  task automatic verifica(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s at %0t: observed=%h expected=%h", tag, $time, obs, exp_v);
    end
  endtask

  task automatic ciclo();
    @(posedge clk);
    modelo(0);
    modelo(1);
    #1;
    verifica("a.linhas", linhas_a, e_lin[0]);
    verifica("a.colunas", 7'(colunas_a), 7'(e_col[0]));
    verifica("a.carregado", 7'(carregado_a), 7'(e_car[0]));
    verifica("a.fim_quadro", 7'(fim_quadro_a), 7'(e_fim[0]));
    verifica("b.linhas", linhas_b, e_lin[1]);
    verifica("b.colunas", 7'(colunas_b), 7'(e_col[1]));
    verifica("b.carregado", 7'(carregado_b), 7'(e_car[1]));
    verifica("b.fim_quadro", 7'(fim_quadro_b), 7'(e_fim[1]));
  endtask

  task automatic rnd_cols();
    coluna1 = 7'($urandom);
    coluna2 = 7'($urandom);
    coluna3 = 7'($urandom);
    coluna4 = 7'($urandom);
    coluna5 = 7'($urandom);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    habilita = 1'b0;
    carregar = 1'b0;
    coluna1 = 7'h7F; coluna2 = 7'h7F; coluna3 = 7'h7F; coluna4 = 7'h7F; coluna5 = 7'h7F;
    repeat (2) ciclo();

    // Scan with an empty buffer; input patterns wander but must never be latched.
    reset = 1'b0;
    habilita = 1'b1;
    repeat (65) begin rnd_cols(); ciclo(); end

    // Single mid-frame load request, visible only after the next boundary.
    rnd_cols();
    coluna1 = 7'h3C;
    coluna5 = 7'h77;
    repeat (7) ciclo();
    carregar = 1'b1; ciclo(); carregar = 1'b0;
    repeat (70) ciclo();

    // Request exactly on the wrap edge of the gapped instance.
    n = 0;
    while (!(m_run[0] && m_t[0] == F0 - 1) && n < 100) begin ciclo(); n++; end
    rnd_cols();
    carregar = 1'b1; ciclo(); carregar = 1'b0;
    repeat (5) ciclo();

    // Three requests within one frame merge into one latch.
    repeat (3) begin
      rnd_cols();
      carregar = 1'b1; ciclo(); carregar = 1'b0;
      repeat (3) ciclo();
    end
    repeat (40) ciclo();

    // Disable while the third column is lit, then resume.
    n = 0;
    while (e_col[0] !== 5'b00100 && n < 100) begin ciclo(); n++; end
    habilita = 1'b0;
    repeat (4) ciclo();
    habilita = 1'b1;
    repeat (12) ciclo();

    // Load while idle.
    habilita = 1'b0;
    repeat (2) ciclo();
    rnd_cols();
    carregar = 1'b1; ciclo(); carregar = 1'b0;
    repeat (3) ciclo();
    habilita = 1'b1;
    repeat (35) ciclo();

    // Reset during the gap with a load pending; the pending request is dropped.
    n = 0;
    while (!(m_run[0] && (m_t[0] % P0) == D) && n < 100) begin ciclo(); n++; end
    rnd_cols();
    carregar = 1'b1; ciclo(); carregar = 1'b0;
    reset = 1'b1; ciclo(); reset = 1'b0;
    repeat (40) ciclo();

    // Random soak.
    repeat (400) begin
      rnd_cols();
      habilita = (($urandom % 16) != 0);
      carregar = (($urandom % 8) == 0);
      reset    = (($urandom % 200) == 0);
      ciclo();
    end
    reset = 1'b0;
    carregar = 1'b0;
    repeat (5) ciclo();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
